// File: rtl/interrupt_controller.sv
// Four-source vectored interrupt controller: synchronised edge capture into a
// pending register, mask gating, fixed priority (bit 0 highest), ack/EOI handshake.
//
// state   | meaning
// --------+--------------------------------------------------------------
// ST_IDLE | no request outstanding; waiting for an enabled pending bit
// ST_REQ  | interrupt asserted to the processor, waiting for int_ack
// ST_SERV | handler running; no nesting until int_eoi
module interrupt_controller #(
   parameter logic [15:0] VECTOR_BASE = 16'h00F0,
   parameter logic [3:0]  MASK_RESET  = 4'hF
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic [3:0]  i_irq_in,
   input  logic        i_mask_we,
   input  logic [3:0]  i_mask_wdata,
   input  logic        i_int_ack,
   input  logic        i_int_eoi,
   output logic        o_interrupt,
   output logic [15:0] o_int_vector,
   output logic [1:0]  o_int_id,
   output logic [3:0]  o_pending,
   output logic [3:0]  o_mask,
   output logic        o_in_service
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_SERV = 2'd2
   } state_t;

   state_t      r_state;
   logic [3:0]  r_sync1;
   logic [3:0]  r_sync2;
   logic [3:0]  r_prev;
   logic [3:0]  r_pending;
   logic [3:0]  r_mask;
   logic        r_interrupt;
   logic        r_in_service;
   logic [1:0]  r_int_id;
   logic [15:0] r_int_vector;

   logic [3:0]  w_edge;
   logic [3:0]  w_req;
   logic [1:0]  w_ack_id;
   logic        w_take_ack;
   logic [3:0]  w_clr;
   logic [15:0] w_vector;

   assign w_edge = r_sync2 & ~r_prev;
   assign w_req  = r_pending & r_mask;

   always_comb begin
      w_ack_id = 2'd0;
      casez (w_req)
         4'b???1: w_ack_id = 2'd0;
         4'b??10: w_ack_id = 2'd1;
         4'b?100: w_ack_id = 2'd2;
         4'b1000: w_ack_id = 2'd3;
         default: w_ack_id = 2'd0;
      endcase
   end

   assign w_take_ack = (r_state == ST_REQ) && i_int_ack && (w_req != 4'b0000);
   assign w_clr      = w_take_ack ? (4'b0001 << w_ack_id) : 4'b0000;
   assign w_vector   = VECTOR_BASE + {12'd0, w_ack_id, 2'b00};

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state      <= ST_IDLE;
         r_sync1      <= 4'b0000;
         r_sync2      <= 4'b0000;
         r_prev       <= 4'b0000;
         r_pending    <= 4'b0000;
         r_mask       <= MASK_RESET;
         r_interrupt  <= 1'b0;
         r_in_service <= 1'b0;
         r_int_id     <= 2'd0;
         r_int_vector <= 16'h0000;
      end else begin
         r_sync1   <= i_irq_in;
         r_sync2   <= r_sync1;
         r_prev    <= r_sync2;
         // a fresh edge on the bit being acked must survive the clear
         r_pending <= (r_pending & ~w_clr) | w_edge;
         if (i_mask_we)
            r_mask <= i_mask_wdata;

         case (r_state)
            ST_IDLE: begin
               if (w_req != 4'b0000) begin
                  r_state     <= ST_REQ;
                  r_interrupt <= 1'b1;
               end
            end
            ST_REQ: begin
               if (w_take_ack) begin
                  r_state      <= ST_SERV;
                  r_interrupt  <= 1'b0;
                  r_in_service <= 1'b1;
                  r_int_id     <= w_ack_id;
                  r_int_vector <= w_vector;
               end else if (w_req == 4'b0000) begin
                  r_state     <= ST_IDLE;
                  r_interrupt <= 1'b0;
               end
            end
            ST_SERV: begin
               if (i_int_eoi) begin
                  r_state      <= ST_IDLE;
                  r_in_service <= 1'b0;
               end
            end
            default: begin
               r_state      <= ST_IDLE;
               r_interrupt  <= 1'b0;
               r_in_service <= 1'b0;
            end
         endcase
      end
   end

   assign o_interrupt  = r_interrupt;
   assign o_int_vector = r_int_vector;
   assign o_int_id     = r_int_id;
   assign o_pending    = r_pending;
   assign o_mask       = r_mask;
   assign o_in_service = r_in_service;

endmodule

// File: tb/tb_interrupt_controller.sv
// Bench for interrupt_controller: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a behavioural model.
module tb_interrupt_controller;

   localparam logic [15:0] VB      = 16'h00F0;
   localparam logic [15:0] VB_WRAP = 16'hFFF8;
   localparam logic [3:0]  MR      = 4'hF;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  irq_in;
   logic        mask_we;
   logic [3:0]  mask_wdata;
   logic        int_ack;
   logic        int_eoi;

   logic        d_interrupt;
   logic [15:0] d_int_vector;
   logic [1:0]  d_int_id;
   logic [3:0]  d_pending;
   logic [3:0]  d_mask;
   logic        d_in_service;

   logic        w_interrupt;
   logic [15:0] w_int_vector;
   logic [1:0]  w_int_id;
   logic [3:0]  w_pending;
   logic [3:0]  w_mask;
   logic        w_in_service;

   int total = 0;
   int bad   = 0;
   bit chk_on = 1'b0;

   always #5 clk = ~clk;

   interrupt_controller #(.VECTOR_BASE(VB), .MASK_RESET(MR)) dut (
      .i_clk(clk), .i_reset(reset), .i_irq_in(irq_in), .i_mask_we(mask_we),
      .i_mask_wdata(mask_wdata), .i_int_ack(int_ack), .i_int_eoi(int_eoi),
      .o_interrupt(d_interrupt), .o_int_vector(d_int_vector), .o_int_id(d_int_id),
      .o_pending(d_pending), .o_mask(d_mask), .o_in_service(d_in_service)
   );

   // second instance only to exercise 16-bit wraparound of the vector sum
   interrupt_controller #(.VECTOR_BASE(VB_WRAP), .MASK_RESET(MR)) dut_wrap (
      .i_clk(clk), .i_reset(reset), .i_irq_in(irq_in), .i_mask_we(mask_we),
      .i_mask_wdata(mask_wdata), .i_int_ack(int_ack), .i_int_eoi(int_eoi),
      .o_interrupt(w_interrupt), .o_int_vector(w_int_vector), .o_int_id(w_int_id),
      .o_pending(w_pending), .o_mask(w_mask), .o_in_service(w_in_service)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // hist[k] is irq_in as seen k+1 edges before the current one; an edge is
   // recognised when the input seen two edges back is high and three back was low.
   logic [3:0]  hist [3];
   logic [3:0]  m_pend, m_mask, rise, req, clr;
   int          m_mode, nmode;   // 0 idle, 1 requesting, 2 servicing
   logic        m_int, m_svc;
   int          m_id;
   logic [15:0] m_vec, m_vec_wrap;

   always @(posedge clk) begin
      if (reset) begin
         for (int k = 0; k < 3; k++) hist[k] = 4'b0;
         m_pend = 4'b0; m_mask = MR; m_mode = 0; m_int = 1'b0; m_svc = 1'b0;
         m_id = 0; m_vec = 16'h0; m_vec_wrap = 16'h0;
      end else begin
         rise  = hist[1] & ~hist[2];
         req   = m_pend & m_mask;
         clr   = 4'b0;
         nmode = m_mode;
         if (m_mode == 0) begin
            if (req != 0) nmode = 1;
         end else if (m_mode == 1) begin
            if (int_ack && req != 0) begin
               m_id = 0;
               while (!req[m_id]) m_id++;
               clr[m_id]  = 1'b1;
               m_vec      = 16'(int'(VB) + 4 * m_id);
               m_vec_wrap = 16'(int'(VB_WRAP) + 4 * m_id);
               nmode = 2;
            end else if (req == 0) nmode = 0;
         end else begin
            if (int_eoi) nmode = 0;
         end
         m_pend = (m_pend & ~clr) | rise;
         if (mask_we) m_mask = mask_wdata;
         m_mode = nmode;
         m_int  = (nmode == 1);
         m_svc  = (nmode == 2);
         hist[2] = hist[1]; hist[1] = hist[0]; hist[0] = irq_in;
      end
   end

   always @(negedge clk) begin
      if (chk_on) begin
         check("cmp_interrupt",  d_interrupt,  m_int);
         check("cmp_in_service", d_in_service, m_svc);
         check("cmp_pending",    d_pending,    m_pend);
         check("cmp_mask",       d_mask,       m_mask);
         check("cmp_int_id",     d_int_id,     m_id);
         check("cmp_int_vector", d_int_vector, m_vec);
         check("cmp_vector_wrap", w_int_vector, m_vec_wrap);
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse_ack();
      int_ack = 1'b1; cyc(1); int_ack = 1'b0;
   endtask

   task automatic pulse_eoi();
      int_eoi = 1'b1; cyc(1); int_eoi = 1'b0;
   endtask

   initial begin
      reset = 1'b1; irq_in = 4'b0; mask_we = 1'b0; mask_wdata = 4'b0;
      int_ack = 1'b0; int_eoi = 1'b0;

      // reset, then a single source edge on bit 2
      cyc(1); chk_on = 1'b1; cyc(4);
      check("rst_pending", d_pending, 4'b0);
      check("rst_interrupt", d_interrupt, 1'b0);
      check("rst_in_service", d_in_service, 1'b0);
      check("rst_int_id", d_int_id, 2'd0);
      check("rst_int_vector", d_int_vector, 16'h0);
      check("rst_mask", d_mask, 4'hF);
      check("model_rst_mask", m_mask, 4'hF);
      reset = 1'b0; irq_in = 4'b0100;
      cyc(2);
      check("sync_pend_e2", d_pending, 4'b0000);
      cyc(1);
      check("sync_pend_e3", d_pending, 4'b0100);
      check("sync_int_e3", d_interrupt, 1'b0);
      check("model_pend_e3", m_pend, 4'b0100);
      cyc(1);
      check("int_e4", d_interrupt, 1'b1);
      pulse_ack();
      check("ack2_id", d_int_id, 2'd2);
      check("ack2_vec", d_int_vector, 16'h00F8);
      check("ack2_svc", d_in_service, 1'b1);

      // two sources latched while servicing; priority picks bit 1 first
      irq_in = 4'b1010;
      cyc(3);
      check("svc_pend", d_pending, 4'b1010);
      check("svc_noint", d_interrupt, 1'b0);
      pulse_eoi();
      check("eoi_svc", d_in_service, 1'b0);
      check("eoi_int0", d_interrupt, 1'b0);
      cyc(1);
      check("eoi_int1", d_interrupt, 1'b1);
      pulse_ack();
      check("ack1_id", d_int_id, 2'd1);
      check("ack1_vec", d_int_vector, 16'h00F4);
      check("ack1_pend", d_pending, 4'b1000);
      check("ack1_svc", d_in_service, 1'b1);
      check("ack1_int", d_interrupt, 1'b0);
      check("model_ack1_vec", m_vec, 16'h00F4);
      check("wrap_ack1_vec", w_int_vector, 16'hFFFC);
      pulse_eoi();
      check("eoi2_int0", d_interrupt, 1'b0);
      cyc(1);
      check("eoi2_int1", d_interrupt, 1'b1);
      pulse_ack();
      check("ack3_id", d_int_id, 2'd3);
      check("ack3_vec", d_int_vector, 16'h00FC);
      check("wrap_ack3_vec", w_int_vector, 16'h0004);
      irq_in = 4'b0;
      pulse_eoi();

      // masked source still latches; unmasking raises the request
      mask_we = 1'b1; mask_wdata = 4'b1110; cyc(1); mask_we = 1'b0;
      check("mask_e", d_mask, 4'b1110);
      irq_in = 4'b0001; cyc(1); irq_in = 4'b0; cyc(4);
      check("masked_pend", d_pending, 4'b0001);
      check("masked_int", d_interrupt, 1'b0);
      mask_we = 1'b1; mask_wdata = 4'hF; cyc(1); mask_we = 1'b0;
      check("unmask_int0", d_interrupt, 1'b0);
      cyc(1);
      check("unmask_int1", d_interrupt, 1'b1);
      pulse_ack();
      check("ack0_vec", d_int_vector, 16'h00F0);
      pulse_eoi();

      // new edge on bit 2 lands on the same edge that acks bit 2
      irq_in = 4'b0100; cyc(1);
      irq_in = 4'b0000; cyc(1);
      irq_in = 4'b0100; cyc(1);
      check("race_pend_pre", d_pending, 4'b0100);
      irq_in = 4'b0000; cyc(1);
      check("race_int", d_interrupt, 1'b1);
      pulse_ack();
      check("race_pend", d_pending, 4'b0100);
      check("race_svc", d_in_service, 1'b1);
      check("race_id", d_int_id, 2'd2);

      // reset mid-service with a source held high
      irq_in = 4'b0010; cyc(1);
      reset = 1'b1; cyc(1);
      check("mrst_pend", d_pending, 4'b0);
      check("mrst_svc", d_in_service, 1'b0);
      check("mrst_vec", d_int_vector, 16'h0);
      check("mrst_mask", d_mask, 4'hF);
      cyc(1);
      reset = 1'b0; cyc(2);
      check("mrst_pend_e2", d_pending, 4'b0000);
      cyc(1);
      check("mrst_pend_e3", d_pending, 4'b0010);

      // randomized traffic, checked every cycle by the compare process
      for (int n = 0; n < 4000; n++) begin
         if ($urandom_range(0, 3) == 0) irq_in = irq_in ^ 4'($urandom_range(0, 15));
         mask_we    = ($urandom_range(0, 19) == 0);
         mask_wdata = 4'($urandom_range(0, 15));
         int_ack    = m_int ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 15) == 0);
         int_eoi    = m_svc ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 15) == 0);
         reset      = ($urandom_range(0, 299) == 0);
         cyc(1);
      end
      reset = 1'b0; mask_we = 1'b0; int_ack = 1'b0; int_eoi = 1'b0;
      cyc(2);
      chk_on = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/interrupt_controller.md
INTERRUPT_CONTROLLER -- requirements
Module: interrupt_controller

Interface
REQ-001 Parameter VECTOR_BASE, default 16'h00F0, base address of the interrupt vector table.
REQ-002 Parameter MASK_RESET, default 4'hF, value loaded into the mask register by reset (1 = enabled).
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 irq_in  input  4  raw, asynchronous interrupt sources; bit 0 has the highest priority.
REQ-006 mask_we  input  1  mask register write strobe.
REQ-007 mask_wdata  input  4  new mask value, taken when mask_we=1.
REQ-008 int_ack  input  1  one-cycle acknowledge from the processor.
REQ-009 int_eoi  input  1  one-cycle end-of-interrupt from the processor.
REQ-010 interrupt  output  1  registered request to the processor's interrupt input.
REQ-011 int_vector  output  16  handler address of the acknowledged source.
REQ-012 int_id  output  2  index of the acknowledged source.
REQ-013 pending  output  4  latched-edge pending register.
REQ-014 mask  output  4  current mask register.
REQ-015 in_service  output  1  high while a handler is active.

Function
REQ-016 Each irq_in bit SHALL pass through a 2-flop synchronizer, then a rising-edge detector (sync2 & ~prev).
REQ-017 A detected edge SHALL set pending[i]; from the first clk edge sampling irq_in[i]=1, pending[i] SHALL be 1 after the third edge.
REQ-018 A level held high SHALL set pending once; no re-set until it falls and rises again.
REQ-019 The mask SHALL only gate requests; masked bits SHALL still latch into pending and stay there.
REQ-020 mask_we=1 SHALL load mask_wdata into mask at the next edge.
REQ-021 The FSM SHALL have states IDLE, REQ, and SERVICE; interrupt SHALL be 1 exactly when state=REQ.
REQ-022 IDLE -> REQ when (pending & mask) != 0; otherwise stay in IDLE.
REQ-023 In REQ, if (pending & mask) == 0 (mask changed), the FSM SHALL return to IDLE without an ack.
REQ-024 In REQ with int_ack=1, the controller SHALL select id = the lowest-index set bit of (pending & mask).
REQ-025 On that ack it SHALL latch int_id=id and int_vector=VECTOR_BASE+4*id, clear pending[id], and go to SERVICE, all at the same edge.
REQ-026 The int_vector sum SHALL be 16-bit modulo 2^16 (wraps at 16'hFFFF).
REQ-027 int_id and int_vector SHALL hold until the next ack.
REQ-028 SERVICE: in_service=1 and interrupt=0 (no nesting); new edges SHALL still set pending.
REQ-029 SERVICE -> IDLE on int_eoi=1; any remaining enabled pending bit SHALL reassert interrupt one cycle after IDLE.
REQ-030 int_ack outside REQ and int_eoi outside SERVICE SHALL be ignored.
REQ-031 int_ack and int_eoi together in REQ: the ack is taken and the eoi ignored.
REQ-032 A new edge and an ack-clear on the same pending bit in one cycle: the set SHALL win.
REQ-033 mask_we together with int_ack: arbitration SHALL use the pre-write mask.

Reset
REQ-034 While reset=1 at an edge: state=IDLE; pending, synchronizers, edge-detect flops, int_id, int_vector, in_service and interrupt = 0; mask=MASK_RESET.
REQ-035 Reset SHALL override every other input, including mid-SERVICE and mid-REQ.
REQ-036 An irq_in held high through reset SHALL produce one pending edge after reset is released.

Verification
REQ-037 Reset=1 for 5 cycles, then release -> all outputs 0, mask=4'hF; irq_in=4'b0100 -> pending=4'b0100 after 3 edges, interrupt=1 at the 4th edge.
REQ-038 pending=4'b1010, ack -> int_id=1, int_vector=16'h00F4, pending=4'b1000, in_service=1, interrupt=0.
REQ-039 eoi from REQ-038 -> IDLE, interrupt=1 one cycle later; ack -> int_id=3, int_vector=16'h00FC.
REQ-040 Mask=4'b1110 with irq_in[0] pulsed -> pending=4'b0001, interrupt stays 0; write mask=4'hF -> interrupt=1.
REQ-041 irq_in[2] rises in the same cycle that pending[2] is acked (pending[2] still 1 afterward) -> pending[2]=1, in_service=1.
REQ-042 reset asserted mid-SERVICE with irq_in[1] held high -> all cleared, then pending=4'b0010 three edges after release.
